// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
//
// Purpose: FSM state encoding and default operand width used by
//          serial_adder_ctrl and its full-adder datapath cell.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// rtl/serial_adder_ctrl_full_adder.sv - one-bit full-adder cell
//
// Purpose: single-bit combinational full adder, time-multiplexed by
//          serial_adder_ctrl over all operand bit positions.
// Ports:
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  sum bit
//   co    out  carry out
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer with valid/ready handshakes
//
// Purpose: adds two WIDTH-bit operands plus carry-in, LSB first, one bit per
//          clock through a single full-adder cell. Result {cout,sum} is held
//          with out_valid until the consumer takes it.
// Optional: define SERIAL_ADDER_SUB_EN to add the 'sub' input (a - b mode).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid, in_ready    operand handshake; a, b, cin captured on accept
//   sub                   (SERIAL_ADDER_SUB_EN only) subtract select
//   out_valid, out_ready  result handshake; sum, cout valid while out_valid
//   busy                  high while an operation is in RUN or DONE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic             last_bit;

  // Operand conditioning at capture time: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub | cin;
`else
  assign b_load   = b;
  assign cin_load = cin;
`endif

  serial_adder_ctrl_full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign sum_next = WIDTH'({fa_s, sum_sr} >> 1);
  assign last_bit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr    <= a;
            b_sr    <= b_load;
            carry_q <= cin_load;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_sr  <= sum_next;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= fa_co;
          if (last_bit) begin
            // Counter is left at WIDTH-1 rather than wrapping; reloaded on accept.
            sum_q       <= sum_next;
            cout_q      <= fa_co;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Present operands for one accept edge; caller ensures the DUT is in IDLE.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    a        = ta;
    b        = tb_v;
    cin      = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({cout, sum} !== 9'h000) begin bad++; $display("FAIL reset_result: got %h want 000", {cout, sum}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", in_ready); end
    send(8'h3C, 8'h15, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_out(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
    total++; if (sum !== 8'h51) begin bad++; $display("FAIL basic_sum: got %h want 51", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL basic_cout: got %b want 0", cout); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_done_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_release: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_ready: got %b want 1", in_ready); end
    total++; if (sum !== 8'h51) begin bad++; $display("FAIL basic_retain: got %h want 51", sum); end
  endtask

  task automatic test_backpressure();
    int lat;
    send(8'hA5, 8'h5A, 1'b0);
    wait_out(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL bp_latency: got %0d want 8", lat); end
    for (int i = 0; i < 5; i++) begin
      a        = 8'h11;
      b        = 8'h22;
      cin      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      total++; if ({cout, sum} !== 9'h0FF) begin bad++; $display("FAIL bp_result[%0d]: got %h want 0ff", i, {cout, sum}); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept: got busy=%b want 0", busy); end
    total++; if ({cout, sum} !== 9'h0FF) begin bad++; $display("FAIL bp_retain: got %h want 0ff", {cout, sum}); end
  endtask

  task automatic test_carry();
    logic [W-1:0] va [2] = '{8'hFF, 8'hFF};
    logic [W-1:0] vb [2] = '{8'h01, 8'hFF};
    logic         vc [2] = '{1'b0, 1'b1};
    logic [W:0]   ve [2] = '{9'h100, 9'h1FF};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(va[i], vb[i], vc[i]);
      wait_out(lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL carry_latency[%0d]: got %0d want 8", i, lat); end
      total++; if ({cout, sum} !== ve[i]) begin bad++; $display("FAIL carry_result[%0d]: got %h want %h", i, {cout, sum}, ve[i]); end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen = 0;
    send(8'h3C, 8'h15, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_run_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_run_ready: got %b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_run_busy: got %b want 0", busy); end
    total++; if ({cout, sum} !== 9'h000) begin bad++; $display("FAIL rst_run_result: got %h want 000", {cout, sum}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_run_no_output: got %0d valid cycles want 0", seen); end
    send(8'h01, 8'h02, 1'b0);
    wait_out(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL rst_run_next_latency: got %0d want 8", lat); end
    total++; if ({cout, sum} !== 9'h003) begin bad++; $display("FAIL rst_run_next_result: got %h want 003", {cout, sum}); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [W:0] exp_q[$];
    logic [W:0] e;
    logic       pre;
    int n_acc    = 0;
    int n_res    = 0;
    int cyc      = 0;
    int last_acc = -1;
    out_ready = 1'b1;
    a         = 8'($urandom);
    b         = 8'($urandom);
    cin       = 1'($urandom);
    in_valid  = 1'b1;
    while (n_res < 200 && cyc < 2500) begin
      pre = in_ready & in_valid;
      @(posedge clk);
      #1;
      cyc++;
      if (pre) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        if (last_acc >= 0) begin
          total++; if (cyc - last_acc !== 10) begin bad++; $display("FAIL stream_interval: got %0d want 10", cyc - last_acc); end
        end
        last_acc = cyc;
        n_acc++;
        if (n_acc >= 200) begin
          in_valid = 1'b0;
        end else begin
          a   = 8'($urandom);
          b   = 8'($urandom);
          cin = 1'($urandom);
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL stream_spurious: got out_valid=1 want no result pending");
        end else begin
          e = exp_q.pop_front();
          total++; if ({cout, sum} !== e) begin bad++; $display("FAIL stream_result[%0d]: got %h want %h", n_res, {cout, sum}, e); end
        end
        n_res++;
      end
    end
    total++; if (n_res !== 200) begin bad++; $display("FAIL stream_count: got %0d want 200", n_res); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    out_ready = 1'b1;
    sub       = 1'b1;
    send(8'h10, 8'h01, 1'b0);
    wait_out(lat);
    total++; if ({cout, sum} !== 9'h10F) begin bad++; $display("FAIL sub_no_borrow: got %h want 10f", {cout, sum}); end
    @(posedge clk);
    #1;
    send(8'h00, 8'h01, 1'b1);
    wait_out(lat);
    total++; if ({cout, sum} !== 9'h0FF) begin bad++; $display("FAIL sub_borrow: got %h want 0ff", {cout, sum}); end
    @(posedge clk);
    #1;
    sub = 1'b0;
    send(8'h10, 8'h01, 1'b0);
    wait_out(lat);
    total++; if ({cout, sum} !== 9'h011) begin bad++; $display("FAIL sub_off_add: got %h want 011", {cout, sum}); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_carry();
    test_reset_mid_run();
    test_streaming();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
